// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control constants for hazard_ctrl and the ID/EX, EX/MEM
// pipeline registers: stall codes, zero word and hazard FSM state encodings.
package hazard_ctrl_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    // Stall vector: bit0/bit1 freeze PC and IF/ID (bubble into ID/EX),
    // bit2 additionally freezes ID/EX and EX/MEM.
    localparam logic [2:0] STALL_NONE            = 3'b000;
    localparam logic [2:0] STALL_ID              = 3'b011;
    localparam logic [2:0] STALL_MASK_IDEX_EXMEM = 3'b100;
    localparam logic [2:0] STALL_MEM             = STALL_ID | STALL_MASK_IDEX_EXMEM;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_MEM_BUSY = 2'b01,
        ST_FLUSH    = 2'b10
    } hz_state_e;

    // True when a stall vector freezes the ID/EX and EX/MEM registers.
    function automatic logic stall_freezes_exmem(input logic [2:0] stall_v);
        return ((stall_v & STALL_MASK_IDEX_EXMEM) != STALL_NONE);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bus between hazard_ctrl (master: drives stall, clear and
// forwarding) and the pipeline stages (slave: drive register-use, result and
// memory handshake information).
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
);
    logic [REG_AW-1:0] id_r1_addr;
    logic              id_r1_used;
    logic [REG_AW-1:0] id_r2_addr;
    logic              id_r2_used;
    logic [REG_AW-1:0] ex_rd_addr;
    logic              ex_wb_en;
    logic              ex_is_load;
    logic [XLEN-1:0]   ex_result;
    logic              ex_branch_taken;
    logic [REG_AW-1:0] mem_rd_addr;
    logic              mem_wb_en;
    logic              mem_is_load;
    logic [XLEN-1:0]   mem_result;
    logic              mem_req;
    logic              mem_done;

    logic [2:0]        stall;
    logic              clear;
    logic              forward_ex_enable;
    logic [REG_AW-1:0] forward_ex_addr;
    logic [XLEN-1:0]   forward_ex_data;
    logic              forward_mem_enable;
    logic [REG_AW-1:0] forward_mem_addr;
    logic [XLEN-1:0]   forward_mem_data;

    modport master (
        input  id_r1_addr, id_r1_used, id_r2_addr, id_r2_used,
        input  ex_rd_addr, ex_wb_en, ex_is_load, ex_result, ex_branch_taken,
        input  mem_rd_addr, mem_wb_en, mem_is_load, mem_result, mem_req, mem_done,
        output stall, clear,
        output forward_ex_enable, forward_ex_addr, forward_ex_data,
        output forward_mem_enable, forward_mem_addr, forward_mem_data
    );

    modport slave (
        output id_r1_addr, id_r1_used, id_r2_addr, id_r2_used,
        output ex_rd_addr, ex_wb_en, ex_is_load, ex_result, ex_branch_taken,
        output mem_rd_addr, mem_wb_en, mem_is_load, mem_result, mem_req, mem_done,
        input  stall, clear,
        input  forward_ex_enable, forward_ex_addr, forward_ex_data,
        input  forward_mem_enable, forward_mem_addr, forward_mem_data
    );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Combinational forwarding selection for the EX and MEM stages.
// x0 is never forwarded, an EX load has no result yet, and a MEM load only
// forwards in the cycle its data returns. Data is zero whenever disabled.
module hazard_ctrl_fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              kill_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              ex_wb_en_i,
    input  logic              ex_is_load_i,
    input  logic [XLEN-1:0]   ex_result_i,
    input  logic [REG_AW-1:0] mem_rd_addr_i,
    input  logic              mem_wb_en_i,
    input  logic              mem_is_load_i,
    input  logic              mem_done_i,
    input  logic [XLEN-1:0]   mem_result_i,
    output logic              ex_en_o,
    output logic [REG_AW-1:0] ex_addr_o,
    output logic [XLEN-1:0]   ex_data_o,
    output logic              mem_en_o,
    output logic [REG_AW-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_data_o
);

    logic ex_en_s;
    logic mem_en_s;

    // Enable terms; both stages may forward the same register, the consumer
    // gives EX precedence.
    always_comb begin
        ex_en_s  = ex_wb_en_i && !ex_is_load_i && (ex_rd_addr_i != {REG_AW{1'b0}});
        mem_en_s = mem_wb_en_i && (mem_rd_addr_i != {REG_AW{1'b0}})
                   && (!mem_is_load_i || mem_done_i);
    end

    // Drive forwarding buses, all zero while killed (reset).
    always_comb begin
        if (kill_i) begin
            ex_en_o    = 1'b0;
            ex_addr_o  = {REG_AW{1'b0}};
            ex_data_o  = {XLEN{1'b0}};
            mem_en_o   = 1'b0;
            mem_addr_o = {REG_AW{1'b0}};
            mem_data_o = {XLEN{1'b0}};
        end else begin
            ex_en_o    = ex_en_s;
            ex_addr_o  = ex_rd_addr_i;
            ex_data_o  = ex_en_s ? ex_result_i : {XLEN{1'b0}};
            mem_en_o   = mem_en_s;
            mem_addr_o = mem_rd_addr_i;
            mem_data_o = mem_en_s ? mem_result_i : {XLEN{1'b0}};
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline hazard controller: stall vector, flush pulse and EX/MEM
// forwarding. A three-state FSM (IDLE / MEM_BUSY / FLUSH) tracks multi-cycle
// memory stalls; pend_flush remembers a branch resolved during such a stall.
// All outputs are combinational from registered state plus current inputs.
// Optional build macro HAZARD_PERF_CNT_EN adds three 32-bit perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    hazard_ctrl_if.master bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]   perf_mem_stall_cycles,
    output logic [31:0]   perf_load_use_stalls,
    output logic [31:0]   perf_flushes
`endif
);

    hz_state_e state_q, state_d;
    logic      pend_flush_q, pend_flush_d;

    logic       mem_stall_s;
    logic       flush_s;
    logic       load_use_s;
    logic [2:0] stall_s;
    logic       clear_s;

    // Hazard detection terms shared by next-state and output logic.
    always_comb begin
        mem_stall_s = !bus.mem_done && ((state_q == ST_MEM_BUSY) || bus.mem_req);
        flush_s     = bus.ex_branch_taken || (state_q == ST_FLUSH) || pend_flush_q;
        load_use_s  = bus.ex_is_load && bus.ex_wb_en
                      && (bus.ex_rd_addr != {REG_AW{1'b0}})
                      && ((bus.id_r1_used && (bus.id_r1_addr == bus.ex_rd_addr))
                       || (bus.id_r2_used && (bus.id_r2_addr == bus.ex_rd_addr)));
    end

    // State register: synchronous reset, frozen while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            pend_flush_q <= 1'b0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            pend_flush_q <= pend_flush_d;
        end else begin
            state_q      <= state_q;
            pend_flush_q <= pend_flush_q;
        end
    end

    // Next-state logic; a memory stall overrides everything and captures any
    // branch so the flush survives the stall.
    always_comb begin
        state_d      = state_q;
        pend_flush_d = pend_flush_q;
        if (mem_stall_s) begin
            state_d      = ST_MEM_BUSY;
            pend_flush_d = pend_flush_q || bus.ex_branch_taken;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = bus.ex_branch_taken ? ST_FLUSH : ST_IDLE;
                    pend_flush_d = 1'b0;
                end
                ST_MEM_BUSY: begin
                    // mem_done this cycle: leave, flushing if a branch is owed
                    state_d      = (pend_flush_q || bus.ex_branch_taken) ? ST_FLUSH : ST_IDLE;
                    pend_flush_d = 1'b0;
                end
                ST_FLUSH: begin
                    state_d      = ST_IDLE;
                    pend_flush_d = 1'b0;
                end
                default: begin
                    state_d      = ST_IDLE;
                    pend_flush_d = 1'b0;
                end
            endcase
        end
    end

    // Output logic in priority order: memory stall, flush, load-use, none.
    always_comb begin
        if (rst_in) begin
            stall_s = STALL_NONE;
            clear_s = 1'b0;
        end else if (mem_stall_s) begin
            stall_s = STALL_MEM;
            clear_s = 1'b0;
        end else if (flush_s) begin
            stall_s = STALL_NONE;
            clear_s = 1'b1;
        end else if (load_use_s) begin
            stall_s = STALL_ID;
            clear_s = 1'b0;
        end else begin
            stall_s = STALL_NONE;
            clear_s = 1'b0;
        end
    end

    assign bus.stall = stall_s;
    assign bus.clear = clear_s;

    hazard_ctrl_fwd_sel #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_fwd_sel (
        .kill_i        (rst_in),
        .ex_rd_addr_i  (bus.ex_rd_addr),
        .ex_wb_en_i    (bus.ex_wb_en),
        .ex_is_load_i  (bus.ex_is_load),
        .ex_result_i   (bus.ex_result),
        .mem_rd_addr_i (bus.mem_rd_addr),
        .mem_wb_en_i   (bus.mem_wb_en),
        .mem_is_load_i (bus.mem_is_load),
        .mem_done_i    (bus.mem_done),
        .mem_result_i  (bus.mem_result),
        .ex_en_o       (bus.forward_ex_enable),
        .ex_addr_o     (bus.forward_ex_addr),
        .ex_data_o     (bus.forward_ex_data),
        .mem_en_o      (bus.forward_mem_enable),
        .mem_addr_o    (bus.forward_mem_addr),
        .mem_data_o    (bus.forward_mem_data)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] mem_cnt_q, luse_cnt_q, flush_cnt_q;
    logic        flush_enter_s;

    // A branch event enters flush exactly when the FSM moves into FLUSH.
    always_comb begin
        flush_enter_s = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);
    end

    // Performance counters; wrap naturally, advance only when ready.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_cnt_q   <= 32'd0;
            luse_cnt_q  <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else if (rdy_in) begin
            mem_cnt_q   <= mem_cnt_q   + {31'd0, stall_freezes_exmem(stall_s)};
            luse_cnt_q  <= luse_cnt_q  + {31'd0, (stall_s == STALL_ID)};
            flush_cnt_q <= flush_cnt_q + {31'd0, flush_enter_s};
        end else begin
            mem_cnt_q   <= mem_cnt_q;
            luse_cnt_q  <= luse_cnt_q;
            flush_cnt_q <= flush_cnt_q;
        end
    end

    assign perf_mem_stall_cycles = rst_in ? ZeroWord : mem_cnt_q;
    assign perf_load_use_stalls  = rst_in ? ZeroWord : luse_cnt_q;
    assign perf_flushes          = rst_in ? ZeroWord : flush_cnt_q;
`endif

endmodule
